uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 tb/tb_uart_tx_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Frame-level round-robin arbiter in front of the UART TX FIFO write port.
// A grant lasts until a byte flagged last is written, or until the owner stalls for TIMEOUT cycles.
module uart_tx_arb #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [31:0]          tx_fifo_wdata_o,
  output logic                 tx_wr_en_o,
  input  logic                 tx_full_i,
  output logic [2:0]           grant_id_o,
  output logic                 busy_o,
  output logic                 timeout_err_o,
  input  logic                 err_clr_i
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q;
  logic [2:0]       grant_id_q;
  logic [2:0]       rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       wdata_q;
  logic             busy_q;
  logic             timeout_err_q;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [7:0]           req_byte [NUM_REQ];
  logic [7:0]           g_byte;
  logic                 g_valid;
  logic                 g_last;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic                 pick_found;
  logic [2:0]           pick_idx;
  logic                 stall_fire;
  logic                 accept_en;
  logic                 xfer;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_byte[gi] = req_data_i[8*gi +: 8];
    assign grant_oh[gi] = (grant_id_q == 3'(gi));
  end

  always_comb begin
    g_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) g_byte = req_byte[i];
    end
  end

  assign g_valid = |(req_valid_i & grant_oh);
  assign g_last  = |(req_last_i & grant_oh);

  // Doubled valid vector turns the modulo scan from rr_ptr+1 into a plain window;
  // scanning downward leaves the lowest in-window hit, i.e. the first in round-robin order.
  assign valid_dbl = {req_valid_i, req_valid_i};

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (valid_dbl[j] && (j > int'(rr_ptr_q)) && (j <= int'(rr_ptr_q) + NUM_REQ)) begin
        pick_found = 1'b1;
        pick_idx   = (j >= NUM_REQ) ? 3'(j - NUM_REQ) : 3'(j);
      end
    end
  end

  // The release cycle accepts nothing, so a late-arriving byte waits for a fresh grant.
  assign stall_fire = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT));
  assign accept_en  = (state_q == GRANT) && !tx_full_i && !stall_fire;
  assign xfer       = accept_en && g_valid;

  assign req_ready_o     = accept_en ? grant_oh : '0;
  assign tx_wr_en_o      = xfer;
  assign tx_fifo_wdata_o = {24'b0, xfer ? g_byte : wdata_q};
  assign grant_id_o      = grant_id_q;
  assign busy_o          = busy_q;
  assign timeout_err_o   = timeout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= 3'(NUM_REQ - 1);
      cnt_q         <= '0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (err_clr_i) timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q <= pick_idx;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (stall_fire) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            rr_ptr_q      <= grant_id_q;
            cnt_q         <= '0;
            timeout_err_q <= 1'b1;
          end else if (xfer) begin
            wdata_q <= g_byte;
            cnt_q   <= '0;
            if (g_last) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= grant_id_q;
            end
          end else if (!g_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: per-requester byte sources, a cycle-stepped reference
// model of the arbitration rules, and a monitor that checks status every cycle and bytes on write.
module tb_uart_tx_arb;
  localparam int NR = 3;
  localparam int TO = 8;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         gap;
  } item_t;

  typedef struct {
    logic [NR-1:0] ready;
    logic          wr;
    logic [7:0]    wdata;
    logic          busy;
    int            owner;
    logic          err;
  } st_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic [31:0]     wdata;
  logic            wr_en, tx_full, busy, terr, err_clr;
  logic [2:0]      gid;

  int checks = 0;
  int errors = 0;

  item_t      src_q [NR][$];
  int         wait_cnt [NR];
  logic [NR-1:0] acc;
  logic [7:0] exp_q [$];
  st_t        st_q [$];

  bit         m_busy, m_err;
  int         m_owner, m_ptr, m_stall;
  logic [7:0] m_wdata;

  bit rand_full, full_force, clr_force, clr_on_fire, rand_clr;

  uart_tx_arb #(.NUM_REQ(NR), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_fifo_wdata_o(wdata), .tx_wr_en_o(wr_en),
    .tx_full_i(tx_full), .grant_id_o(gid), .busy_o(busy),
    .timeout_err_o(terr), .err_clr_i(err_clr)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_owner = 0; m_ptr = NR - 1; m_stall = 0; m_wdata = '0;
  endtask

  task automatic push_item(input int i, input logic [7:0] d, input logic last, input int gap);
    item_t it;
    it.d = d; it.last = last; it.gap = gap;
    src_q[i].push_back(it);
  endtask

  task automatic add_frame(input int i, input int len, input bit stall_mid);
    for (int b = 0; b < len; b++)
      push_item(i, 8'($urandom), logic'(b == len - 1),
                (stall_mid && b == 1) ? int'($urandom_range(TO + 6, TO + 1)) : int'($urandom_range(2)));
  endtask

  // One clock cycle: drive at negedge, predict at +1, advance the model to the next edge.
  task automatic step();
    bit fire, wr, found, set;
    st_t s;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        req_valid[i] = 1'b0;
        wait_cnt[i]  = 0;
      end else if (!req_valid[i]) begin
        wait_cnt[i]++;
      end
      if (!req_valid[i] && src_q[i].size() > 0 && wait_cnt[i] >= src_q[i][0].gap) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0].d;
        req_last[i]        = src_q[i][0].last;
      end
    end
    acc = '0;
    tx_full = rand_full ? ($urandom_range(3) == 0) : full_force;
    fire = m_busy && (m_stall == TO);
    err_clr = clr_force | (clr_on_fire & fire) | (rand_clr & ($urandom_range(15) == 0));
    #1;
    for (int i = 0; i < NR; i++) acc[i] = req_valid[i] & req_ready[i];

    wr = m_busy && !fire && !tx_full && req_valid[m_owner];
    s.ready = (m_busy && !fire && !tx_full) ? NR'(1 << m_owner) : '0;
    s.wr    = wr;
    if (wr) begin
      m_wdata = req_data[8*m_owner +: 8];
      exp_q.push_back(m_wdata);
    end
    s.wdata = m_wdata; s.busy = m_busy; s.owner = m_owner; s.err = m_err;
    st_q.push_back(s);

    if (rst_n) begin
      set = 0;
      found = 0;
      if (!m_busy) begin
        for (int k = 1; k <= NR; k++) begin
          int c = (m_ptr + k) % NR;
          if (!found && req_valid[c]) begin
            found = 1; m_busy = 1; m_owner = c; m_stall = 0;
          end
        end
      end else if (fire) begin
        m_busy = 0; m_ptr = m_owner; set = 1;
      end else if (wr) begin
        m_stall = 0;
        if (req_last[m_owner]) begin m_busy = 0; m_ptr = m_owner; end
      end else if (!req_valid[m_owner]) begin
        m_stall++;
      end
      if (set) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic drain();
    int c = 0;
    while ((m_busy || src_q[0].size() + src_q[1].size() + src_q[2].size() > 0 || req_valid != '0) && c < 400) begin
      step();
      c++;
    end
    chk("drain_bound", 32'(c < 400), 32'd1);
  endtask

  // Monitor: status every cycle, bytes whenever the FIFO is written.
  initial begin
    st_t e;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        if (e.busy) chk("grant_id", 32'(gid), 32'(e.owner));
        chk("timeout_err", 32'(terr), 32'(e.err));
        chk("req_ready", 32'(req_ready), 32'(e.ready));
        chk("tx_wr_en", 32'(wr_en), 32'(e.wr));
        chk("wdata", wdata, {24'b0, e.wdata});
      end
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", wdata, 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          $display("tx byte %02h from req %0d", wdata[7:0], gid);
          chk("tx_byte", wdata, {24'b0, b});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 0; req_valid = '0; req_last = '0; req_data = '0; tx_full = 0; err_clr = 0;
    acc = '0; rand_full = 0; full_force = 0; clr_force = 0; clr_on_fire = 0; rand_clr = 0;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    model_reset();
    #25;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_err", 32'(terr), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // single two-byte frame
    push_item(0, 8'h41, 0, 0); push_item(0, 8'h42, 1, 0);
    drain();

    // two competing 3-byte frames, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 3; b++) begin
        push_item(0, 8'hA0 + 8'(b), logic'(b == 2), 0);
        push_item(1, 8'hB0 + 8'(b), logic'(b == 2), 0);
      end
    end
    drain();

    // back-pressure mid-frame is not a stall
    for (int b = 0; b < 4; b++) push_item(1, 8'hC0 + 8'(b), logic'(b == 3), 0);
    run(3);
    full_force = 1; run(10); full_force = 0;
    drain();
    chk("no_timeout_on_full", 32'(terr), 32'd0);

    // stalled owner is released, pending requester then granted
    push_item(0, 8'h10, 0, 0); push_item(0, 8'h11, 1, TO + 6);
    push_item(1, 8'hD0, 0, 2); push_item(1, 8'hD1, 1, 0);
    drain();
    chk("timeout_err_set", 32'(terr), 32'd1);
    clr_force = 1; step(); clr_force = 0; step();
    chk("timeout_err_cleared", 32'(terr), 32'd0);

    // set and clear on the same edge: set wins
    clr_on_fire = 1;
    push_item(2, 8'h20, 0, 0); push_item(2, 8'h21, 1, TO + 6);
    drain();
    clr_on_fire = 0;
    chk("set_beats_clr", 32'(terr), 32'd1);

    // asynchronous reset while requester 1 owns the port mid-frame
    for (int b = 0; b < 6; b++) push_item(1, 8'hE0 + 8'(b), logic'(b == 5), 0);
    c = 0;
    while (!(m_busy && m_owner == 1) && c < 20) begin step(); c++; end
    chk("reach_grant1", 32'(c < 20), 32'd1);
    step(); step();
    #3;
    rst_n = 0;
    #2;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_err", 32'(terr), 32'd0);
    model_reset();
    for (int i = 0; i < NR; i++) begin src_q[i].delete(); wait_cnt[i] = 0; end
    req_valid = '0; acc = '0;
    run(2);
    @(negedge clk);
    rst_n = 1;
    push_item(1, 8'h61, 1, 0); push_item(0, 8'h51, 1, 0);
    drain();

    // randomized traffic
    rand_full = 1; rand_clr = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NR; i++)
        if (src_q[i].size() == 0 && $urandom_range(3) == 0)
          add_frame(i, $urandom_range(4, 1), $urandom_range(9) == 0);
      step();
    end
    rand_full = 0; rand_clr = 0;
    drain();

    #3;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
